// File: rtl/irq_gateway.sv
// Interrupt gateway: latches edge pulses into per-source pending state, raises a
// registered level interrupt, and arbitrates claim/complete from the trap handler.
//
// state   | meaning
// IDLE    | no interrupt outstanding for this source
// PENDING | pulse latched, waiting to be claimed
// ACTIVE  | claimed by the handler, waiting for complete
module irq_gateway #(
    parameter int NUM_SRC = 8,
    localparam int ID_W = $clog2(NUM_SRC + 1)
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [NUM_SRC-1:0] irq_pulse,
    input  logic [NUM_SRC-1:0] irq_enable,
    output logic               ext_irq,
    output logic [NUM_SRC-1:0] irq_pending,
    input  logic               claim_req,
    output logic               claim_valid,
    output logic [ID_W-1:0]    claim_id,
    input  logic               complete_req,
    input  logic [ID_W-1:0]    complete_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACTIVE  = 2'd2
    } src_state_e;

    src_state_e         state_q [NUM_SRC];
    src_state_e         state_d [NUM_SRC];
    logic [NUM_SRC-1:0] replay_q, replay_d;
    logic               ext_irq_q, ext_irq_d;
    logic               claim_valid_q, claim_valid_d;
    logic [ID_W-1:0]    claim_id_q, claim_id_d;

    logic [NUM_SRC-1:0] claimable;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] complete_hit;
    logic [ID_W-1:0]    win_id;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                state_q[i] <= IDLE;
            end
            replay_q      <= '0;
            ext_irq_q     <= 1'b0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                state_q[i] <= state_d[i];
            end
            replay_q      <= replay_d;
            ext_irq_q     <= ext_irq_d;
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
        end
    end

    // Arbitration works on registered state only, so a pulse or completion in
    // the same cycle can never be granted until the following claim.
    always_comb begin
        claimable = irq_pending & irq_enable;
        grant     = claim_req ? (claimable & (~claimable + NUM_SRC'(1))) : '0;
        win_id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (claimable[i]) begin
                win_id = ID_W'(i + 1);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            complete_hit[i] = complete_req && (complete_id == ID_W'(i + 1));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            state_d[i]  = state_q[i];
            replay_d[i] = replay_q[i];
            case (state_q[i])
                IDLE: begin
                    if (irq_pulse[i]) state_d[i] = PENDING;
                end
                PENDING: begin
                    if (grant[i]) state_d[i] = ACTIVE;
                end
                ACTIVE: begin
                    if (complete_hit[i]) begin
                        state_d[i]  = (replay_q[i] || irq_pulse[i]) ? PENDING : IDLE;
                        replay_d[i] = 1'b0;
                    end else if (irq_pulse[i]) begin
                        replay_d[i] = 1'b1;
                    end
                end
                default: begin
                    state_d[i]  = IDLE;
                    replay_d[i] = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            irq_pending[i] = (state_q[i] == PENDING);
        end
        ext_irq_d     = |claimable;
        claim_valid_d = claim_req;
        claim_id_d    = claim_req ? win_id : '0;
        ext_irq       = ext_irq_q;
        claim_valid   = claim_valid_q;
        claim_id      = claim_id_q;
    end

endmodule
